// File: rtl/rom_read_arbiter_if.sv
// Request/response and ROM-port bundle for rom_read_arbiter.
// slave = arbiter side, master = requesters plus ROM model.
interface rom_read_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_REQ    = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ-1:0]            rsp_ready;
  logic [31:0]                   rsp_data;
  logic [ADDR_WIDTH-1:0]         rom_addr;
  logic [31:0]                   rom_data;

  modport slave (
    input  req_valid, req_addr, rsp_ready, rom_data,
    output req_ready, rsp_valid, rsp_data, rom_addr
  );

  modport master (
    output req_valid, req_addr, rsp_ready, rom_data,
    input  req_ready, rsp_valid, rsp_data, rom_addr
  );
endinterface

// File: rtl/rom_read_arbiter.sv
// Shares one registered-read ROM port among NUM_REQ requesters; 2-cycle latency, 1 read/cycle.
// Grant stalls only when S1 and S2 are both full and S2 is held. Define ROM_ARB_FIXED_PRIO_EN for fixed priority.
module rom_read_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_REQ    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  rom_read_arbiter_if.slave  bus
);

  localparam int ID_W = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  logic                  inflight_v_q, inflight_v_d;
  logic [ID_W-1:0]       inflight_id_q, inflight_id_d;
  logic                  rsp_v_q, rsp_v_d;
  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
  logic [31:0]           rsp_data_q, rsp_data_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;

  logic                  found;
  logic [ID_W-1:0]       win;
  logic [ID_W-1:0]       idx;
  logic [NUM_REQ-1:0]    rsp_valid_w;
  logic                  rsp_fire;
  logic                  s1_stall;
  logic                  issue;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] win_addr;

`ifndef ROM_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0] rr_q, rr_d;
  logic [ID_W:0]   scan_sum;
  logic [ID_W:0]   rr_nxt;
`endif

  assign rsp_valid_w = rsp_v_q ? (ONE_HOT0 << rsp_id_q) : '0;
  assign rsp_fire    = |(rsp_valid_w & bus.rsp_ready);
  assign s1_stall    = inflight_v_q && rsp_v_q && !rsp_fire;
  assign xfer        = inflight_v_q && (!rsp_v_q || rsp_fire);

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
`ifndef ROM_ARB_FIXED_PRIO_EN
    scan_sum = '0;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
      idx = ID_W'(k);
`else
      scan_sum = {1'b0, rr_q} + (ID_W+1)'(k);
      if (scan_sum >= (ID_W+1)'(NUM_REQ))
        scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
      idx = scan_sum[ID_W-1:0];
`endif
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Reset gates the grant so nothing is handshaken while the pipeline is held clear.
  assign issue    = rst_n && !s1_stall && found;
  assign win_addr = bus.req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];

  assign bus.req_ready = issue ? (ONE_HOT0 << win) : '0;
  assign bus.rsp_valid = rsp_valid_w;
  assign bus.rsp_data  = rsp_data_q;
  // Without an issue the ROM re-reads last_addr, so a stalled S1 keeps valid rom_data.
  assign bus.rom_addr  = issue ? win_addr : last_addr_q;

  always_comb begin
    last_addr_d   = last_addr_q;
    inflight_id_d = inflight_id_q;
    inflight_v_d  = s1_stall;
    rsp_v_d       = rsp_v_q;
    rsp_id_d      = rsp_id_q;
    rsp_data_d    = rsp_data_q;
    if (issue) begin
      last_addr_d   = win_addr;
      inflight_v_d  = 1'b1;
      inflight_id_d = win;
    end
    if (xfer) begin
      rsp_v_d    = 1'b1;
      rsp_id_d   = inflight_id_q;
      rsp_data_d = bus.rom_data;
    end else if (rsp_fire) begin
      rsp_v_d = 1'b0;
    end
  end

`ifndef ROM_ARB_FIXED_PRIO_EN
  always_comb begin
    rr_d   = rr_q;
    rr_nxt = {1'b0, win} + (ID_W+1)'(1);
    if (rr_nxt >= (ID_W+1)'(NUM_REQ))
      rr_nxt = '0;
    if (issue)
      rr_d = rr_nxt[ID_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= '0;
    else        rr_q <= rr_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_v_q  <= 1'b0;
      inflight_id_q <= '0;
      rsp_v_q       <= 1'b0;
      rsp_id_q      <= '0;
      rsp_data_q    <= '0;
      last_addr_q   <= '0;
    end else begin
      inflight_v_q  <= inflight_v_d;
      inflight_id_q <= inflight_id_d;
      rsp_v_q       <= rsp_v_d;
      rsp_id_q      <= rsp_id_d;
      rsp_data_q    <= rsp_data_d;
      last_addr_q   <= last_addr_d;
    end
  end

endmodule
